// File: rtl/rx_fifo_ctrl_mux.sv
// ----------------------------------------------------------------------------
// rx_fifo_ctrl_mux
// Rx FIFO byte serialiser for up to NR receivers. On spd_rdy it snapshots the
// I/Q samples of every receiver and streams the selected base receiver first,
// then each receiver flagged in Sync (ascending, base excluded). Every sample
// goes out MSB-first as bytes: I bytes, then Q bytes. A full FIFO sends the
// block into CLEAR, which requests a flush until the FIFO reports empty.
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-low
//   Rx_number      base receiver index (values >= NR select receiver 0)
//   data_in_I/Q    flattened samples, receiver k at [k*SW +: SW]
//   spd_rdy        new sample set available (level)
//   Sync           extra receivers to send after the base
//   fifo_full      Rx byte FIFO full
//   Rx_fifo_empty  Rx byte FIFO empty
//   wrenable       byte write strobe (registered)
//   data_out       byte to the FIFO (registered, holds when idle)
//   convert_state  combinational: idle in WAIT with no pending sample set
//   fifo_clear     FIFO flush request (registered)
//   clear_count    saturating count of flush events (registered)
// ----------------------------------------------------------------------------
module rx_fifo_ctrl_mux #(
   parameter int unsigned NR           = 8,
   parameter int unsigned SAMPLE_BYTES = 3,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [$clog2(NR)-1:0]           Rx_number,
   input  logic [NR*8*SAMPLE_BYTES-1:0]    data_in_I,
   input  logic [NR*8*SAMPLE_BYTES-1:0]    data_in_Q,
   input  logic                            spd_rdy,
   input  logic [NR-1:0]                   Sync,
   input  logic                            fifo_full,
   input  logic                            Rx_fifo_empty,
   output logic                            wrenable,
   output logic [7:0]                      data_out,
   output logic                            convert_state,
   output logic                            fifo_clear,
   output logic [CNT_W-1:0]                clear_count
);

   localparam int unsigned SW     = 8 * SAMPLE_BYTES;
   localparam int unsigned CH_W   = $clog2(NR);
   localparam int unsigned NBYTES = 2 * SAMPLE_BYTES;
   localparam int unsigned BIDX_W = $clog2(NBYTES);
   localparam int unsigned VEC_W  = NR * SW;

   localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NBYTES - 1);

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_SEND  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   state_t              state_q,   state_d;
   logic [VEC_W-1:0]    snap_i_q,  snap_i_d;
   logic [VEC_W-1:0]    snap_q_q,  snap_q_d;
   logic [CH_W-1:0]     cur_ch_q,  cur_ch_d;
   logic [NR-1:0]       pend_q,    pend_d;
   logic [BIDX_W-1:0]   byte_q,    byte_d;
   logic                wr_q,      wr_d;
   logic [7:0]          dout_q,    dout_d;
   logic                clr_q,     clr_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic [CH_W-1:0]     base_c;

   // Byte idx of a channel's slot: 0..SB-1 walk I from MSB, SB..2SB-1 walk Q.
   function automatic logic [7:0] pick_byte(input logic [VEC_W-1:0]  iv,
                                            input logic [VEC_W-1:0]  qv,
                                            input logic [CH_W-1:0]   ch,
                                            input logic [BIDX_W-1:0] idx);
      logic [SW-1:0] s;
      int unsigned   sel;
      if (32'(idx) < SAMPLE_BYTES) begin
         s   = iv[32'(ch) * SW +: SW];
         sel = SAMPLE_BYTES - 1 - 32'(idx);
      end else begin
         s   = qv[32'(ch) * SW +: SW];
         sel = NBYTES - 1 - 32'(idx);
      end
      return s[sel * 8 +: 8];
   endfunction

   // Lowest set bit of the pending mask gives the next channel in ascending order.
   function automatic logic [CH_W-1:0] lowest_set(input logic [NR-1:0] m);
      logic [CH_W-1:0] r;
      r = '0;
      for (int i = NR - 1; i >= 0; i--) begin
         if (m[i]) r = CH_W'(i);
      end
      return r;
   endfunction

   // Out-of-range base receiver falls back to receiver 0.
   always_comb begin
      base_c = Rx_number;
      if (32'(Rx_number) >= NR) base_c = '0;
   end

   // State and datapath registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= ST_WAIT;
         snap_i_q <= '0;
         snap_q_q <= '0;
         cur_ch_q <= '0;
         pend_q   <= '0;
         byte_q   <= '0;
         wr_q     <= 1'b0;
         dout_q   <= 8'h00;
         clr_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         snap_i_q <= snap_i_d;
         snap_q_q <= snap_q_d;
         cur_ch_q <= cur_ch_d;
         pend_q   <= pend_d;
         byte_q   <= byte_d;
         wr_q     <= wr_d;
         dout_q   <= dout_d;
         clr_q    <= clr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      snap_i_d = snap_i_q;
      snap_q_d = snap_q_q;
      cur_ch_d = cur_ch_q;
      pend_d   = pend_q;
      byte_d   = byte_q;
      wr_d     = 1'b0;
      dout_d   = dout_q;
      clr_d    = 1'b0;
      cnt_d    = cnt_q;

      case (state_q)
         ST_WAIT: begin
            if (fifo_full) begin
               // Flush has priority; a pending sample set waits for the return.
               state_d = ST_CLEAR;
               clr_d   = 1'b1;
               if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end else if (spd_rdy) begin
               snap_i_d         = data_in_I;
               snap_q_d         = data_in_Q;
               cur_ch_d         = base_c;
               pend_d           = Sync;
               pend_d[base_c]   = 1'b0;
               byte_d           = '0;
               wr_d             = 1'b1;
               dout_d           = pick_byte(data_in_I, data_in_Q, base_c, '0);
               state_d          = ST_SEND;
            end
         end

         ST_SEND: begin
            wr_d = 1'b1;
            if (byte_q == LAST_BYTE) begin
               if (pend_q == '0) begin
                  wr_d    = 1'b0;
                  state_d = ST_HOLD;
               end else begin
                  // Move straight to the next channel so wrenable has no gap.
                  cur_ch_d         = lowest_set(pend_q);
                  pend_d[cur_ch_d] = 1'b0;
                  byte_d           = '0;
                  dout_d           = pick_byte(snap_i_q, snap_q_q, cur_ch_d, '0);
               end
            end else begin
               byte_d = byte_q + BIDX_W'(1);
               dout_d = pick_byte(snap_i_q, snap_q_q, cur_ch_q, byte_d);
            end
         end

         ST_HOLD: begin
            if (!spd_rdy) state_d = ST_WAIT;
         end

         ST_CLEAR: begin
            clr_d = 1'b1;
            if (Rx_fifo_empty) begin
               clr_d   = 1'b0;
               state_d = ST_WAIT;
            end
         end

         default: begin
            state_d = ST_WAIT;
         end
      endcase
   end

   assign wrenable      = wr_q;
   assign data_out      = dout_q;
   assign fifo_clear    = clr_q;
   assign clear_count   = cnt_q;
   assign convert_state = (state_q == ST_WAIT) && !spd_rdy;

endmodule
